// File: rtl/c_hazard_controller.sv
// Hazard/sequencing controller for the 5-stage core: load-use bubbles, redirect
// flushes and the multi-cycle EX hold, plus a saturating stall-cycle counter.
module c_hazard_controller #(
    parameter int         MC_LATENCY = 4,
    parameter logic [1:0] MC_PATH    = 2'b11,
    parameter int         CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             RegWE_W_E,
    input  logic [1:0]       ExPathE,
    input  logic             branch_taken_E,
    input  logic             jump_E,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             mc_start,
    output logic             mc_done,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int                  MC_CNT_W  = $clog2(MC_LATENCY);
    localparam logic [MC_CNT_W-1:0] MC_RELOAD = MC_CNT_W'(MC_LATENCY - 2);

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    state_t              state_reg;
    logic [MC_CNT_W-1:0] mc_cnt_reg;
    logic [CNT_W-1:0]    stall_cnt_reg;

    logic [1:0] src_match;
    logic       lu_hz;
    logic       redirect;
    logic       mc_req;
    logic       mc_trigger;
    logic       mc_hold;
    logic       mc_final;
    logic       mc_stall;
    logic       stall_f_next;

    // One comparator per ID source operand against the EX destination.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            if (gi == 0) begin : g_rs1
                assign src_match[gi] = (RdE == Rs1D);
            end else begin : g_rs2
                assign src_match[gi] = (RdE == Rs2D);
            end
        end
    endgenerate

    assign lu_hz    = RegWE_W_E & (RdE != 5'd0) & (|src_match);
    assign redirect = branch_taken_E | jump_E;
    assign mc_req   = (ExPathE == MC_PATH);

    assign mc_trigger = (state_reg == IDLE) & mc_req;
    assign mc_hold    = (state_reg == MC_BUSY) & (mc_cnt_reg != '0);
    assign mc_final   = (state_reg == MC_BUSY) & (mc_cnt_reg == '0);
    // While the MC unit owns EX, ID-side hazards wait; the done cycle behaves like IDLE.
    assign mc_stall   = mc_trigger | mc_hold;

    assign stall_f_next = mc_stall | (~redirect & lu_hz);

    always_comb begin
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        mc_start = 1'b0;
        mc_done  = 1'b0;
        mc_busy  = 1'b0;
        if (!reset) begin
            mc_start = mc_trigger;
            mc_done  = mc_final;
            mc_busy  = (state_reg == MC_BUSY);
            if (mc_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
            end else if (redirect) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lu_hz) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            mc_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mc_req) begin
                        state_reg  <= MC_BUSY;
                        mc_cnt_reg <= MC_RELOAD;
                    end
                end
                MC_BUSY: begin
                    if (mc_cnt_reg != '0) begin
                        mc_cnt_reg <= mc_cnt_reg - MC_CNT_W'(1);
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    mc_cnt_reg <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (stall_f_next && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_c_hazard_controller.sv
// Bench for c_hazard_controller: directed hazard scenarios with literal checks,
// then randomized traffic compared every cycle against a residency-based model.
module tb_c_hazard_controller;

    localparam int         L     = 4;
    localparam int         CW    = 4;
    localparam logic [1:0] MCP   = 2'b11;
    localparam int         SMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [4:0]    Rs1D = '0, Rs2D = '0, RdE = '0;
    logic          RegWE_W_E = 1'b0;
    logic [1:0]    ExPathE = '0;
    logic          branch_taken_E = 1'b0, jump_E = 1'b0;
    logic          StallF, StallD, StallE, FlushD, FlushE;
    logic          mc_start, mc_done, mc_busy;
    logic [CW-1:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    c_hazard_controller #(.MC_LATENCY(L), .MC_PATH(MCP), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .RegWE_W_E(RegWE_W_E), .ExPathE(ExPathE), .branch_taken_E(branch_taken_E),
        .jump_E(jump_E), .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .mc_start(mc_start), .mc_done(mc_done),
        .mc_busy(mc_busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: age of the MC instruction in EX (-1 when none), stall count.
    int m_age = -1;
    int m_cnt = 0;
    int nxt_age = -1;
    int nxt_cnt = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_age <= -1;
            m_cnt <= 0;
        end else begin
            m_age <= nxt_age;
            m_cnt <= nxt_cnt;
        end
    end

    always @(negedge clk) begin
        int  e;
        logic lu, rd, sf, sd, se, fd, fe, st, dn, bz;
        sf = 0; sd = 0; se = 0; fd = 0; fe = 0; st = 0; dn = 0; bz = 0;
        if (reset) begin
            nxt_age = -1;
            nxt_cnt = 0;
            chk("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        end else begin
            e  = (m_age >= 0) ? m_age : ((ExPathE == MCP) ? 0 : -1);
            lu = RegWE_W_E && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
            rd = branch_taken_E || jump_E;
            if (e >= 0 && e < L - 1) begin
                sf = 1; sd = 1; se = 1;
            end else if (rd) begin
                fd = 1; fe = 1;
            end else if (lu) begin
                sf = 1; sd = 1; fe = 1;
            end
            st = (e == 0);
            dn = (e == L - 1);
            bz = (e >= 1);
            nxt_age = (e >= 0 && e < L - 1) ? e + 1 : -1;
            nxt_cnt = (sf && m_cnt < SMAX) ? m_cnt + 1 : m_cnt;
            chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
        end
        chk("StallF", 32'(StallF), 32'(sf));
        chk("StallD", 32'(StallD), 32'(sd));
        chk("StallE", 32'(StallE), 32'(se));
        chk("FlushD", 32'(FlushD), 32'(fd));
        chk("FlushE", 32'(FlushE), 32'(fe));
        chk("mc_start", 32'(mc_start), 32'(st));
        chk("mc_done", 32'(mc_done), 32'(dn));
        chk("mc_busy", 32'(mc_busy), 32'(bz));
    end

    // One cycle of stimulus: apply after the rising edge, return at the falling edge.
    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic rw, input logic [1:0] p, input logic b, input logic j);
        @(posedge clk);
        #1;
        Rs1D = r1; Rs2D = r2; RdE = rd; RegWE_W_E = rw;
        ExPathE = p; branch_taken_E = b; jump_E = j;
        @(negedge clk);
        $display("txn t=%0t rs1=%0d rs2=%0d rd=%0d rw=%0b path=%0d br=%0b j=%0b -> SF=%0b SE=%0b FD=%0b FE=%0b st=%0b dn=%0b bz=%0b cnt=%0d",
                 $time, r1, r2, rd, rw, p, b, j, StallF, StallE, FlushD, FlushE,
                 mc_start, mc_done, mc_busy, stall_cycles);
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        int starts, dones;
        #1 reset = 1'b1;
        @(negedge clk);
        chk("lit_reset_StallF", 32'(StallF), 32'd0);
        chk("lit_reset_busy", 32'(mc_busy), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle();
        chk("lit_post_reset_cnt", 32'(stall_cycles), 32'd0);

        // Load-use on x5 through Rs2D: exactly one bubble.
        drive(5'd0, 5'd5, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("lit_lu_StallF", 32'(StallF), 32'd1);
        chk("lit_lu_FlushE", 32'(FlushE), 32'd1);
        chk("lit_lu_StallE", 32'(StallE), 32'd0);
        idle();
        chk("lit_lu_cnt", 32'(stall_cycles), 32'd1);
        drive(5'd0, 5'd0, 5'd0, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("lit_lu_x0_StallF", 32'(StallF), 32'd0);

        // Redirect wins over load-use.
        drive(5'd0, 5'd5, 5'd5, 1'b1, 2'b00, 1'b1, 1'b0);
        chk("lit_br_FlushD", 32'(FlushD), 32'd1);
        chk("lit_br_FlushE", 32'(FlushE), 32'd1);
        chk("lit_br_StallF", 32'(StallF), 32'd0);

        // Single MC instruction, 4 cycles of residency.
        for (int c = 0; c < L; c++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, MCP, 1'b0, 1'b0);
            chk("lit_mc_start", 32'(mc_start), 32'(c == 0));
            chk("lit_mc_StallE", 32'(StallE), 32'(c < 3));
            chk("lit_mc_done", 32'(mc_done), 32'(c == 3));
            chk("lit_mc_busy", 32'(mc_busy), 32'(c >= 1));
        end
        idle();
        chk("lit_mc_cnt", 32'(stall_cycles), 32'd4);

        // Back-to-back MC instructions.
        starts = 0; dones = 0;
        for (int c = 0; c < 2 * L; c++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, MCP, 1'b0, 1'b0);
            if (mc_start) starts++;
            if (mc_done) dones++;
            if (c == 4) chk("lit_b2b_second_start", 32'(mc_start), 32'd1);
        end
        idle();
        chk("lit_b2b_starts", 32'(starts), 32'd2);
        chk("lit_b2b_dones", 32'(dones), 32'd2);
        chk("lit_b2b_cnt", 32'(stall_cycles), 32'd10);

        // Reset during MC_BUSY: immediate clear, then a clean restart.
        drive(5'd0, 5'd0, 5'd0, 1'b0, MCP, 1'b0, 1'b0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, MCP, 1'b0, 1'b0);
        chk("lit_rb_busy_before", 32'(mc_busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("lit_rb_StallF", 32'(StallF), 32'd0);
        chk("lit_rb_StallE", 32'(StallE), 32'd0);
        chk("lit_rb_busy", 32'(mc_busy), 32'd0);
        chk("lit_rb_done", 32'(mc_done), 32'd0);
        chk("lit_rb_cnt", 32'(stall_cycles), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("lit_rb_restart", 32'(mc_start), 32'd1);
        for (int c = 1; c < L; c++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, MCP, 1'b0, 1'b0);
            chk("lit_rb_done_seq", 32'(mc_done), 32'(c == 3));
        end
        idle();
        chk("lit_rb_cnt_after", 32'(stall_cycles), 32'd3);

        // Saturation at 15 with a 4-bit counter.
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 14; c++) drive(5'd5, 5'd0, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0);
        idle();
        chk("lit_sat_14", 32'(stall_cycles), 32'd14);
        for (int c = 0; c < 5; c++) drive(5'd5, 5'd0, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0);
        idle();
        chk("lit_sat_15", 32'(stall_cycles), 32'd15);

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            reset          = ($urandom_range(0, 199) == 0);
            Rs1D           = 5'($urandom_range(0, 3));
            Rs2D           = 5'($urandom_range(0, 3));
            RdE            = 5'($urandom_range(0, 3));
            RegWE_W_E      = 1'($urandom_range(0, 1));
            ExPathE        = ($urandom_range(0, 3) == 0) ? MCP : 2'($urandom_range(0, 2));
            branch_taken_E = ($urandom_range(0, 7) == 0);
            jump_E         = ($urandom_range(0, 11) == 0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/c_hazard_controller.md
Name: c_hazard_controller

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core.
- Drives StallF/StallD/StallE and FlushD/FlushE into the IF/ID and ID/EX pipeline registers.
- Resolves three hazard classes: load-use hazards, taken branches and jumps, and multi-cycle execute operations on ExPath MC_PATH.
- Holds a multi-cycle instruction in EX for MC_LATENCY cycles via an internal FSM/counter, and keeps a saturating stall-cycle performance counter.

Parameters:
- MC_LATENCY, 4, total cycles a MC_PATH instruction occupies EX; legal range is 2 or more.
- MC_PATH, 2'b11, ExPathE encoding that selects the multi-cycle execute unit.
- CNT_W, 32, width of stall_cycles.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Rs1D  in  5  source register 1 of the instruction in ID.
- Rs2D  in  5  source register 2 of the instruction in ID.
- RdE  in  5  destination register of the instruction in EX.
- RegWE_W_E  in  1  EX instruction writes the register file with a value available only at W (load).
- ExPathE  in  2  execute path select of the instruction in EX.
- branch_taken_E  in  1  branch in EX resolved taken.
- jump_E  in  1  jump in EX.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID register.
- StallE  out  1  hold ID/EX register.
- FlushD  out  1  clear IF/ID register to NOP.
- FlushE  out  1  clear ID/EX register to NOP.
- mc_start  out  1  one-cycle pulse: multi-cycle unit begins operand capture.
- mc_done  out  1  one-cycle pulse: multi-cycle result valid this cycle.
- mc_busy  out  1  FSM in MC_BUSY.
- stall_cycles  out  CNT_W  count of cycles with StallF=1.

Behaviour:
- Reset (asynchronous) puts the FSM in IDLE, clears mc_cnt and clears stall_cycles to 0. While reset is high, all stall/flush/mc outputs are 0.
- Internal signals:
  - lu_hz = RegWE_W_E & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
  - redirect = branch_taken_E | jump_E.
  - mc_req = (ExPathE == MC_PATH).
- FSM states are IDLE and MC_BUSY. The down-counter mc_cnt is ceil(log2(MC_LATENCY)) bits wide.
- IDLE, mc_req=1:
  - StallF = StallD = StallE = 1; mc_start = 1; FlushE = 0.
  - Next cycle: mc_cnt <= MC_LATENCY-2, go to MC_BUSY.
- MC_BUSY, mc_cnt != 0:
  - StallF = StallD = StallE = 1; mc_cnt decrements.
- MC_BUSY, mc_cnt == 0:
  - mc_done = 1; all stalls 0; return to IDLE.
  - The instruction in EX advances at the next edge.
- Total EX residency of an MC instruction is exactly MC_LATENCY cycles. mc_busy = (state == MC_BUSY).
- Back-to-back MC instructions: the next MC instruction enters EX after the done cycle and retriggers from IDLE. There is no idle gap beyond the normal pipeline advance.
- IDLE, no mc_req, priority order:
  1. redirect: FlushD = FlushE = 1; no stalls. The load-use hazard is ignored because the ID instruction is squashed.
  2. lu_hz: StallF = StallD = 1, FlushE = 1 (bubble inserted); StallE = 0. Exactly one bubble per load-use, since the load leaves EX next cycle.
  3. Otherwise all outputs are 0.
- During an MC stall (trigger cycle or MC_BUSY with mc_cnt != 0), lu_hz and redirect are masked. An MC_PATH instruction is never a branch or jump.
- The done cycle (MC_BUSY, mc_cnt == 0) evaluates lu_hz and redirect as in IDLE. Since EX still holds the MC instruction, lu_hz applies only if that instruction drives RegWE_W_E.
- stall_cycles increments on every cycle with StallF = 1 and saturates at all-ones.
- Reset asserted mid MC_BUSY: immediate return to IDLE. No mc_done pulse is produced.
- All outputs except stall_cycles are combinational from state, mc_cnt and the inputs. No output has a path from a D-stage input to StallE.

Test Plan:
- Load into x5 in EX (RegWE_W_E=1, RdE=5) with Rs2D=5 in ID -> StallF=StallD=FlushE=1 for exactly 1 cycle; stall_cycles increments by 1. Same scenario with RdE=0 -> no stall.
- branch_taken_E=1 while lu_hz is also true -> FlushD=FlushE=1, StallF=StallD=0 for that cycle.
- ExPathE=2'b11 held, MC_LATENCY=4 -> mc_start at cycle 0; StallE=1 for cycles 0-2; mc_done at cycle 3 with StallE=0; mc_busy=1 in cycles 1-3; stall_cycles increases by 3.
- Two consecutive MC instructions -> two mc_start pulses 4 cycles apart, two mc_done pulses, 6 stall cycles total.
- Reset asserted in cycle 1 of MC_BUSY -> outputs 0 immediately; after release, FSM is IDLE and stall_cycles is 0; a new MC instruction restarts the full 4-cycle sequence.
- stall_cycles forced near saturation (CNT_W=4, 14 stall cycles then 5 more) -> holds at 15.
